// File: rtl/fetch_stage_pkg.sv
//==============================================================================
// fetch_stage_pkg : shared types/constants for the instruction fetch stage | rev 1.0
//==============================================================================
`default_nettype none

package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam int          WORD_BYTES    = 4;
  localparam int          FETCH_ENTRY_W = 64;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_IDLE   = 2'd0;
  localparam fetch_state_t ST_FETCH  = 2'd1;
  localparam fetch_state_t ST_HALTED = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_buf2.sv
//==============================================================================
// fetch_buf2 : 2-entry synchronous FIFO with flush, push, pop and count | rev 1.0
//==============================================================================
`default_nettype none

module fetch_buf2 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic             w_pop;
  logic             w_push;

  assign w_pop  = i_pop & (r_count != 2'd0);
  assign w_push = i_push & ((r_count != 2'd2) | w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      // Storage is left as-is; only the occupancy is discarded.
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
//==============================================================================
// fetch_stage : PC/FSM, byte-bank word assembly and 2-deep queue to decode | rev 1.0
//==============================================================================
`default_nettype none

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          IMEM_AW  = 8
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [7:0]         imem_b0_data,
  input  logic [7:0]         imem_b1_data,
  input  logic [7:0]         imem_b2_data,
  input  logic [7:0]         imem_b3_data,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               halt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic [31:0]        out_pc,
  output logic               misalign_err
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic         r_misalign;

  logic         w_redirect;
  logic         w_pop;
  logic         w_push;
  logic [1:0]   w_count;
  fetch_entry_t w_wentry;
  fetch_entry_t w_head;

  assign imem_addr  = r_pc[IMEM_AW+1:2];
  assign w_wentry   = '{pc: r_pc, instr: {imem_b3_data, imem_b2_data, imem_b1_data, imem_b0_data}};

  // Redirects are meaningless before the first fetch, so IDLE drops them.
  assign w_redirect = redirect_valid & (r_state != ST_IDLE);
  assign out_valid  = (w_count != 2'd0);
  assign w_pop      = out_valid & out_ready;
  assign w_push     = (r_state == ST_FETCH) & ~halt & ~w_redirect &
                      ((w_count != 2'd2) | w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   r_state <= ST_FETCH;
        ST_FETCH:  r_state <= halt ? ST_HALTED : ST_FETCH;
        ST_HALTED: r_state <= halt ? ST_HALTED : ST_FETCH;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
    end else if (w_redirect) begin
      r_pc <= {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) begin
        r_misalign <= 1'b1;
      end
    end else if (w_push) begin
      r_pc <= r_pc + 32'(WORD_BYTES);
    end
  end

  fetch_buf2 #(
    .WIDTH (FETCH_ENTRY_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_redirect),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wentry),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  assign out_pc       = w_head.pc;
  assign out_instr    = w_head.instr;
  assign misalign_err = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
//==============================================================================
// tb_fetch_stage : directed vector table plus reset/IDLE/wrap sequences | rev 1.0
//==============================================================================
`default_nettype none

module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  imem_addr;
  logic [7:0]  imem_b0_data, imem_b1_data, imem_b2_data, imem_b3_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic        halt           = 1'b0;
  logic        out_valid;
  logic        out_ready      = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        misalign_err;

  logic [7:0] mem_b0 [256];
  logic [7:0] mem_b1 [256];
  logic [7:0] mem_b2 [256];
  logic [7:0] mem_b3 [256];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign imem_b0_data = mem_b0[imem_addr];
  assign imem_b1_data = mem_b1[imem_addr];
  assign imem_b2_data = mem_b2[imem_addr];
  assign imem_b3_data = mem_b3[imem_addr];

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .IMEM_AW  (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_b0_data   (imem_b0_data),
    .imem_b1_data   (imem_b1_data),
    .imem_b2_data   (imem_b2_data),
    .imem_b3_data   (imem_b3_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .misalign_err   (misalign_err)
  );

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        hlt;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ei;
    logic [7:0]  ea;
    logic        em;
  } vec_t;

  vec_t tv [27];

  function automatic logic [31:0] wd(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_outs(input int cyc, input logic ev, input logic [31:0] epc,
                            input logic [31:0] ei, input logic [7:0] ea, input logic em);
    chk("out_valid", cyc, 32'(out_valid), 32'(ev));
    chk("imem_addr", cyc, 32'(imem_addr), 32'(ea));
    chk("misalign_err", cyc, 32'(misalign_err), 32'(em));
    if (ev) begin
      chk("out_pc", cyc, out_pc, epc);
      chk("out_instr", cyc, out_instr, ei);
    end
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc, input logic hlt);
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt           = hlt;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [31:0] w;
      w = wd(i);
      mem_b0[i] = w[7:0];
      mem_b1[i] = w[15:8];
      mem_b2[i] = w[23:16];
      mem_b3[i] = w[31:24];
    end

    //          rdy rv  rpc            hlt  ev  epc            ei                    ea      em
    tv[0]  = '{1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 32'h0,     32'h0,               8'h00, 1'b0};
    tv[1]  = '{1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 32'h0,     32'h0,               8'h00, 1'b0};
    tv[2]  = '{1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 32'h0,     32'h1000_0000,       8'h01, 1'b0};
    tv[3]  = '{1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 32'h4,     32'h1000_0001,       8'h02, 1'b0};
    // out_ready low for five cycles with 8 at the head
    tv[4]  = '{1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'h8,     32'h1000_0002,       8'h03, 1'b0};
    tv[5]  = '{1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'h8,     32'h1000_0002,       8'h04, 1'b0};
    tv[6]  = '{1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'h8,     32'h1000_0002,       8'h04, 1'b0};
    tv[7]  = '{1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'h8,     32'h1000_0002,       8'h04, 1'b0};
    tv[8]  = '{1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'h8,     32'h1000_0002,       8'h04, 1'b0};
    tv[9]  = '{1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 32'h8,     32'h1000_0002,       8'h04, 1'b0};
    tv[10] = '{1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 32'hC,     32'h1000_0003,       8'h05, 1'b0};
    // redirect to 0x40 with two entries buffered
    tv[11] = '{1'b0, 1'b1, 32'h40,    1'b0, 1'b1, 32'h10,    32'h1000_0004,       8'h06, 1'b0};
    tv[12] = '{1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 32'h0,     32'h0,               8'h10, 1'b0};
    tv[13] = '{1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 32'h40,    32'h1000_0010,       8'h11, 1'b0};
    // redirect to 0x3FC: bank index wraps 255 -> 0
    tv[14] = '{1'b1, 1'b1, 32'h3FC,   1'b0, 1'b1, 32'h44,    32'h1000_0011,       8'h12, 1'b0};
    tv[15] = '{1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 32'h0,     32'h0,               8'hFF, 1'b0};
    tv[16] = '{1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 32'h3FC,   32'h1000_00FF,       8'h00, 1'b0};
    // misaligned redirect to 0x42
    tv[17] = '{1'b1, 1'b1, 32'h42,    1'b0, 1'b1, 32'h400,   32'h1000_0000,       8'h01, 1'b0};
    tv[18] = '{1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 32'h0,     32'h0,               8'h10, 1'b1};
    // halt for four cycles
    tv[19] = '{1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 32'h40,    32'h1000_0010,       8'h11, 1'b1};
    tv[20] = '{1'b1, 1'b0, 32'h0,     1'b1, 1'b0, 32'h0,     32'h0,               8'h11, 1'b1};
    tv[21] = '{1'b1, 1'b0, 32'h0,     1'b1, 1'b0, 32'h0,     32'h0,               8'h11, 1'b1};
    tv[22] = '{1'b1, 1'b0, 32'h0,     1'b1, 1'b0, 32'h0,     32'h0,               8'h11, 1'b1};
    tv[23] = '{1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 32'h0,     32'h0,               8'h11, 1'b1};
    tv[24] = '{1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 32'h0,     32'h0,               8'h11, 1'b1};
    tv[25] = '{1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 32'h44,    32'h1000_0011,       8'h12, 1'b1};
    tv[26] = '{1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 32'h48,    32'h1000_0012,       8'h13, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check_outs(-1, 1'b0, 32'h0, 32'h0, 8'h00, 1'b0);
    chk("rst out_pc", -1, out_pc, 32'h0);
    chk("rst out_instr", -1, out_instr, 32'h0);
    rst = 1'b0;

    for (int k = 0; k < 27; k++) begin
      check_outs(k, tv[k].ev, tv[k].epc, tv[k].ei, tv[k].ea, tv[k].em);
      drive(tv[k].rdy, tv[k].rv, tv[k].rpc, tv[k].hlt);
      @(negedge clk);
    end

    // Asynchronous reset mid-stream: outputs return to reset values before any edge
    chk("pre-rst out_valid", 27, 32'(out_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("async out_valid", 100, 32'(out_valid), 32'h0);
    chk("async out_pc", 100, out_pc, 32'h0);
    chk("async out_instr", 100, out_instr, 32'h0);
    chk("async imem_addr", 100, 32'(imem_addr), 32'h0);
    chk("async misalign", 100, 32'(misalign_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Redirect in IDLE is ignored, including its misalignment
    check_outs(200, 1'b0, 32'h0, 32'h0, 8'h00, 1'b0);
    drive(1'b1, 1'b1, 32'h0000_0082, 1'b0);
    @(negedge clk);
    check_outs(201, 1'b0, 32'h0, 32'h0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check_outs(202, 1'b1, 32'h0, 32'h1000_0000, 8'h01, 1'b0);

    // Full 32-bit PC wraps modulo 2^32
    drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    @(negedge clk);
    check_outs(203, 1'b0, 32'h0, 32'h0, 8'hFF, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check_outs(204, 1'b1, 32'hFFFF_FFFC, 32'h1000_00FF, 8'h00, 1'b0);
    @(negedge clk);
    check_outs(205, 1'b1, 32'h0000_0000, 32'h1000_0000, 8'h01, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage sitting directly upstream of the four byte-lane instruction memories (B0..B3) and downstream-feeding the decode stage. It owns the program counter, drives one shared word address to all four byte banks, assembles the four returned bytes into a 32-bit little-endian instruction, and queues {pc, instr} pairs in a 2-entry buffer toward decode under a valid/ready handshake. It also handles branch/jump redirects, halting and misaligned-target detection.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- IMEM_AW, 8, word-address width of each byte bank (256 entries).
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  IMEM_AW  shared word address to banks B0..B3; equals pc[IMEM_AW+1:2].
- imem_b0_data .. imem_b3_data  in  8 each  combinational read data from banks B0..B3 (B0 = bits 7:0).
- redirect_valid  in  1  branch/jump target valid this cycle.
- redirect_pc  in  32  target byte address.
- halt  in  1  level; stop issuing new fetches.
- out_valid  out  1  buffer head valid toward decode.
- out_ready  in  1  decode accepts head.
- out_instr  out  32  {b3,b2,b1,b0} of head entry.
- out_pc  out  32  byte PC of head entry.
- misalign_err  out  1  sticky; set by a redirect with redirect_pc[1:0] != 0.

## Operation
- FSM states: IDLE, FETCH, HALTED. Reset -> IDLE. IDLE -> FETCH unconditionally next cycle (no fetch in IDLE). FETCH -> HALTED when halt=1; HALTED -> FETCH when halt=0. redirect_valid acts in every state except IDLE (ignored in IDLE).
- Push: in FETCH with halt=0, when count<2 or a pop occurs this cycle: write {pc, assembled instr} to tail, pc <= pc+4.
- Pop: out_valid & out_ready; head advances. Push and pop in same cycle leave count unchanged.
- Redirect (highest priority): buffer cleared (count<=0), pc <= {redirect_pc[31:2],2'b00}, no push that cycle. A pop coinciding with redirect still counts as a completed transfer. If redirect_pc[1:0]!=0, misalign_err <= 1 (cleared only by rst).
- HALTED: no pushes; buffered entries still drain via pops; pc held.
- Arithmetic: pc is 32-bit, pc+4 wraps modulo 2^32. imem_addr uses only pc[IMEM_AW+1:2], so the bank index wraps 255 -> 0 naturally while out_pc keeps the full 32-bit value.
- out_valid = (count != 0). out_instr/out_pc driven from head entry; hold stable while out_valid & !out_ready.
- Reset values: pc=RESET_PC, count=0, state=IDLE, out_valid=0, out_instr=0, out_pc=0, misalign_err=0, imem_addr=RESET_PC[IMEM_AW+1:2]; buffer storage cleared to 0.
- Reset mid-operation: all state returns to reset values immediately (async); in-flight entries discarded.

## Timing
- imem_addr is combinational from the pc register; bank data captured at the same rising edge that advances pc.
- After rst deassert: cycle 0 IDLE, first push at end of cycle 1, out_valid=1 in cycle 2 with out_pc=RESET_PC.
- Redirect asserted in cycle c: out_valid=0 in cycle c+1; target instruction at head with out_valid=1 in cycle c+2.
- Steady state with out_ready=1: one instruction per cycle, no bubbles.
- out_ready deasserted: buffer fills to 2 within two cycles, then pc freezes; after out_ready returns, throughput resumes with no lost or duplicated PCs.
- halt asserted in cycle c: no push at end of c (state moves to HALTED at that edge).

## Structure
- Shared package: FSM state enum (IDLE/FETCH/HALTED), RESET_PC default, word-size constant 4, fetch-entry width (64 bits: pc+instr).
- One natural sub-module: fetch_buf2, a 2-entry synchronous FIFO with flush, push, pop, count; the PC/FSM logic stays in fetch_stage.

## Test plan
- Reset release, banks preloaded word i = 32'h1000_0000+i, out_ready=1 -> out_pc 0,4,8,... with out_instr 1000_0000,1000_0001,... one per cycle from cycle 2.
- out_ready low for 5 cycles starting at out_pc=8 -> out_pc held at 8, count=2, imem_addr frozen at 4; on release sequence continues 8,C,10 with no gaps/duplicates.
- Redirect to 32'h0000_0040 while two entries buffered -> out_valid=0 next cycle, then out_pc=40, out_instr=word 16.
- Redirect to 32'h0000_03FC -> out_pc 3FC then 400 with imem_addr 255 then 0; out_pc keeps full value 400.
- Redirect to 32'h0000_0042 -> misalign_err=1 and stays 1; fetch proceeds from 40.
- halt high 4 cycles with out_ready=1 -> buffer drains to out_valid=0, pc held; halt low -> fetch resumes from next sequential pc; async rst pulse mid-stream -> all outputs to reset values immediately.
